// File: rtl/result_tx_pkg.sv
// Shared types and constants for the result nibble transmitter.
// Holds the FSM state enum and the nibble geometry of a frame.
package result_tx_pkg;

    localparam int NIB_W      = 4;
    localparam int RES_DATA_W = 16;
    localparam int RES_NUM    = 3;
    localparam int NUM_NIB    = RES_NUM * RES_DATA_W / NIB_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHOW,
        GAP,
        FIN
    } tx_state_t;

endpackage

// File: rtl/result_nibble_tx_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with asynchronous active-high reset.
// Ports: clk, reset, d (async input), q (synchronised output).
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/result_nibble_tx.sv
// Snapshots y1..y3 on a rising done and serialises the 12 nibbles
// (y1 first, LS nibble first) onto nib_out with a tick-paced strobe.
// Ports: clk, reset (async, high), tick, done, y1..y3, ack,
//        nib_out, strobe, busy, tx_done.
// Optional ack handshake: define RESULT_TX_ACK_HANDSHAKE_EN.
module result_nibble_tx
    import result_tx_pkg::*;
#(
    parameter int DATA_W       = RES_DATA_W,
    parameter int NUM_RES      = RES_NUM,
    parameter int STROBE_TICKS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              done,
    input  logic [DATA_W-1:0] y1,
    input  logic [DATA_W-1:0] y2,
    input  logic [DATA_W-1:0] y3,
    input  logic              ack,
    output logic [NIB_W-1:0]  nib_out,
    output logic              strobe,
    output logic              busy,
    output logic              tx_done
);

    localparam int SH_W  = NUM_RES * DATA_W;
    localparam int NIBS  = SH_W / NIB_W;
    localparam int IDX_W = $clog2(NIBS);
    localparam int CNT_W = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);
    localparam logic [CNT_W-1:0] CNT_RLD  = CNT_W'(STROBE_TICKS - 1);

    tx_state_t        state;
    logic [SH_W-1:0]  shadow;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [CNT_W-1:0] cnt;
    logic [NIB_W-1:0] nib_nxt;
    logic             done_q;
    logic             primed;
    logic             rise;
    logic             show_go;
    logic             gap_go;

`ifdef RESULT_TX_ACK_HANDSHAKE_EN
    logic ack_s;

    sync_2ff u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ack),
        .q     (ack_s)
    );

    // Strobe drops only once the host has acked; the gap count
    // runs only while the host has released ack.
    assign show_go = ack_s;
    assign gap_go  = ~ack_s;
`else
    logic unused_ack;

    assign unused_ack = ack;
    assign show_go    = 1'b1;
    assign gap_go     = 1'b1;
`endif

    // primed masks the first clk after reset so that a done level
    // already present at release is not mistaken for a rise.
    assign rise    = done & ~done_q & primed;
    assign idx_nxt = idx + 1'b1;

    always_comb begin
        nib_nxt = shadow[idx_nxt*NIB_W +: NIB_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shadow  <= '0;
            idx     <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            primed  <= 1'b0;
            nib_out <= '0;
            strobe  <= 1'b0;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            done_q  <= done;
            primed  <= 1'b1;
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        shadow <= {y3, y2, y1};
                        busy   <= 1'b1;
                        idx    <= '0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (tick) begin
                        nib_out <= shadow[NIB_W-1:0];
                        strobe  <= 1'b1;
                        cnt     <= CNT_RLD;
                        state   <= SHOW;
                    end
                end
                SHOW: begin
                    if (tick) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (show_go) begin
                            strobe <= 1'b0;
                            cnt    <= CNT_RLD;
                            state  <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tick && gap_go) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (idx == LAST_IDX) begin
                            state <= FIN;
                        end else begin
                            idx     <= idx_nxt;
                            nib_out <= nib_nxt;
                            strobe  <= 1'b1;
                            cnt     <= CNT_RLD;
                            state   <= SHOW;
                        end
                    end
                end
                FIN: begin
                    tx_done <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_nibble_tx.sv
// Directed self-checking bench for result_nibble_tx.
// Tick every 4 clk, STROBE_TICKS=3: strobe high 12 clk, gap 12 clk.
module tb_result_nibble_tx;

    typedef logic [3:0] nibs_t [12];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        done = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] y1 = '0;
    logic [15:0] y2 = '0;
    logic [15:0] y3 = '0;
    logic [3:0]  nib_out;
    logic        strobe;
    logic        busy;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

    logic [3:0] nibq[$];
    int         hiq[$];
    int         loq[$];
    int         hi_run = 0;
    int         lo_run = 0;
    bit         fall_seen = 0;
    logic       s_prev = 1'b0;
    logic       t_prev = 1'b0;
    int         frames = 0;
    int         tx_hi = 0;
    int         f0 = 0;
    int         t0 = 0;
    bit         ack_auto = 0;
    logic [1:0] tdiv = '0;

    result_nibble_tx #(
        .DATA_W       (16),
        .NUM_RES      (3),
        .STROBE_TICKS (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .done    (done),
        .y1      (y1),
        .y2      (y2),
        .y3      (y3),
        .ack     (ack),
        .nib_out (nib_out),
        .strobe  (strobe),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tdiv = tdiv + 2'd1;
            tick = (tdiv == 2'd0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ack_auto) ack = strobe;
        end
    end

    always @(negedge clk) begin
        if (strobe && !s_prev) begin
            nibq.push_back(nib_out);
            if (fall_seen) loq.push_back(lo_run);
            hi_run = 1;
        end else if (!strobe && s_prev) begin
            hiq.push_back(hi_run);
            lo_run = 1;
            fall_seen = 1;
        end else if (strobe) begin
            hi_run++;
        end else begin
            lo_run++;
        end
        if (!busy) fall_seen = 0;
        if (tx_done) tx_hi++;
        if (tx_done && !t_prev) frames++;
        s_prev = strobe;
        t_prev = tx_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic prep(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c);
        y1 = a;
        y2 = b;
        y3 = c;
        nibq.delete();
        hiq.delete();
        loq.delete();
        f0 = frames;
        t0 = tx_hi;
    endtask

    task automatic start_frame(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c);
        prep(a, b, c);
        step(2);
        done = 1'b1;
        step(1);
        done = 1'b0;
    endtask

    task automatic finish_frame(input nibs_t exp, input string tag,
                                input bit timing);
        logic [31:0] v;
        for (int i = 0; i < 2000 && frames == f0; i++) step(1);
        chk({tag, "_frames"}, frames - f0, 1);
        chk({tag, "_txlen"}, tx_hi - t0, 1);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_count"}, nibq.size(), 12);
        for (int k = 0; k < 12; k++) begin
            v = (k < nibq.size()) ? {28'd0, nibq[k]} : 'x;
            chk($sformatf("%s_nib%0d", tag, k), v, {28'd0, exp[k]});
        end
        if (timing) begin
            chk({tag, "_hicount"}, hiq.size(), 12);
            chk({tag, "_locount"}, loq.size(), 11);
            foreach (hiq[k]) chk($sformatf("%s_hi%0d", tag, k), hiq[k], 12);
            foreach (loq[k]) chk($sformatf("%s_lo%0d", tag, k), loq[k], 12);
        end
        step(1);
        chk({tag, "_txdrop"}, {31'd0, tx_done}, 0);
    endtask

    initial begin
        int n;
`ifdef RESULT_TX_ACK_HANDSHAKE_EN
        ack_auto = 1;
`endif
        step(3);
        chk("rst_nib", {28'd0, nib_out}, 0);
        chk("rst_strobe", {31'd0, strobe}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_txdone", {31'd0, tx_done}, 0);
        reset = 1'b0;
        step(3);

        start_frame(16'd6, 16'd3, 16'd5);
        finish_frame('{6,0,0,0,3,0,0,0,5,0,0,0}, "basic", 1);
        chk("idle_hold0", {28'd0, nib_out}, 0);

        start_frame(16'hABCD, 16'h1234, 16'hF00F);
        finish_frame('{13,12,11,10,4,3,2,1,15,0,0,15}, "order", 1);
        chk("idle_holdF", {28'd0, nib_out}, 15);

        prep(16'h0021, 16'h0043, 16'h0065);
        step(2);
        done = 1'b1;
        step(800);
        chk("held_frames", frames - f0, 1);
        chk("held_count", nibq.size(), 12);
        done = 1'b0;
        step(50);
        chk("held_after", frames - f0, 1);

        start_frame(16'h1111, 16'h2222, 16'h3333);
        step(100);
        y1 = 16'h9999;
        y2 = 16'h8888;
        y3 = 16'h7777;
        done = 1'b1;
        step(2);
        done = 1'b0;
        step(2);
        done = 1'b1;
        step(2);
        done = 1'b0;
        finish_frame('{1,1,1,1,2,2,2,2,3,3,3,3}, "midtog", 1);
        step(400);
        chk("midtog_nosecond", frames - f0, 1);

        start_frame(16'h0F1E, 16'h2D3C, 16'h4B5A);
        finish_frame('{14,1,15,0,12,3,13,2,10,5,11,4}, "second", 1);

        start_frame(16'd6, 16'd3, 16'd5);
        for (int i = 0; i < 400 && nibq.size() < 5; i++) step(1);
        chk("prerst_nib", {28'd0, nib_out}, 3);
        reset = 1'b1;
        #1;
        chk("async_nib", {28'd0, nib_out}, 0);
        chk("async_strobe", {31'd0, strobe}, 0);
        chk("async_busy", {31'd0, busy}, 0);
        step(2);
        reset = 1'b0;
        step(2);
        start_frame(16'd6, 16'd3, 16'd5);
        finish_frame('{6,0,0,0,3,0,0,0,5,0,0,0}, "postrst", 1);

        prep(16'h4321, 16'h0000, 16'h0000);
        n = 0;
        while (!tick && n < 10) begin
            step(1);
            n++;
        end
        chk("tick_found", {31'd0, tick}, 1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        chk("coin_busy", {31'd0, busy}, 1);
        chk("coin_strobe", {31'd0, strobe}, 0);
        n = 0;
        while (!strobe && n < 20) begin
            step(1);
            n++;
        end
        chk("coin_delay", n, 4);
        finish_frame('{1,2,3,4,0,0,0,0,0,0,0,0}, "coin", 1);

        reset = 1'b1;
        done = 1'b1;
        step(2);
        reset = 1'b0;
        f0 = frames;
        step(200);
        chk("rel_frames", frames - f0, 0);
        chk("rel_busy", {31'd0, busy}, 0);
        chk("rel_strobe", {31'd0, strobe}, 0);
        done = 1'b0;
        step(5);

`ifdef RESULT_TX_ACK_HANDSHAKE_EN
        ack_auto = 0;
        ack = 1'b0;
        start_frame(16'hABCD, 16'h1234, 16'hF00F);
        n = 0;
        while (!strobe && n < 50) begin
            step(1);
            n++;
        end
        chk("hs_first", {31'd0, strobe}, 1);
        step(40);
        chk("hs_hold", {31'd0, strobe}, 1);
        ack = 1'b1;
        step(20);
        chk("hs_dropped", {31'd0, strobe}, 0);
        chk("hs_gapwait", nibq.size(), 1);
        ack = 1'b0;
        n = 0;
        while (!strobe && n < 100) begin
            step(1);
            n++;
        end
        chk("hs_gaplen", {31'd0, (n >= 9 && n <= 20)}, 1);
        ack_auto = 1;
        finish_frame('{13,12,11,10,4,3,2,1,15,0,0,15}, "hs", 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
